delay_12_ring: RTL and testbench
================================

# delay_12_ring

Programmable sample-domain delay for 12-bit peripheral data, built on a circular buffer with a separate write side and read tap. Where the fixed-depth register delay chain produces a constant cycle delay, this block delays by a runtime-configured number of valid samples and reports when the delayed stream is trustworthy. It sits between a 12-bit sample producer (ADC capture path) and consumers that need a given channel realigned against other channels.

## Interface

- WIDTH, 12, sample width
- DEPTH, 64, maximum delay in samples (power of two)
- AW, 6, log2(DEPTH)

- clk  input  1  sole clock, rising edge
- rst  input  1  asynchronous, active-low reset
- in_valid  input  1  one sample accepted per cycle when high
- in  input  WIDTH  sample data, sampled when in_valid=1
- cfg_load  input  1  single-cycle pulse: latch dly_cfg and flush
- dly_cfg  input  AW+1  requested delay in samples, 1..DEPTH
- out  output  WIDTH  delayed sample
- out_valid  output  1  one-cycle pulse marking a valid out
- primed  output  1  buffer holds at least dly samples

## Operation

- Storage: DEPTH x WIDTH array, write pointer wr_ptr (AW bits, wraps DEPTH-1 -> 0), fill counter fill (AW+1 bits, saturates at DEPTH), active delay dly (AW+1 bits).
- dly clamp on load: 0 -> 1; values > DEPTH -> DEPTH.
- On in_valid: mem[wr_ptr] <= in; wr_ptr++; fill++ unless saturated.
- Read tap: rd_addr = (wr_ptr - dly) mod DEPTH, evaluated before the write. dly=DEPTH gives rd_addr = wr_ptr; old content is read before overwrite on the same edge.
- On in_valid with fill >= dly (pre-write value): out <= mem[rd_addr], out_valid <= 1. Otherwise out_valid <= 0 and out holds.
- in_valid=0: out holds, out_valid <= 0, no pointer or fill change.
- primed = (fill >= dly), registered.
- cfg_load: dly <= clamp(dly_cfg), fill <= 0, primed <= 0; wr_ptr and memory untouched. Stale data is never emitted because fill restarts.
- cfg_load with in_valid in the same cycle: the new dly applies and the sample is written, so fill becomes 1. No out_valid is produced for that sample.
- Memory contents are not reset.

## Timing

- Reset values: out=0, out_valid=0, primed=0, wr_ptr=0, fill=0, dly=1.
- Reset is asynchronous assert and synchronous-safe deassert, supplied by the top level. Reset mid-stream discards all history, and the first out_valid after it requires dly+1 new samples.
- Latency: out/out_valid are registered one cycle after the in_valid edge. The sample emitted is the one accepted dly valid-strobes earlier.
- Throughput: one sample per cycle sustained; no backpressure.
- First out_valid after flush accompanies the (dly+1)-th accepted sample.
- fill saturation at DEPTH is required for dly=DEPTH to remain primed indefinitely.

## Structure

- The shared peripheral package holds SAMPLE_W=12 and DELAY_DEPTH_DEF=64, reused by all delay variants.
- One sub-module, delay_12_ring_mem: a simple dual-port array (write port plus asynchronous read port, read-before-write). It is isolated so it can later be swapped for a macro.
- Pointer, fill and clamp logic stay in the top.

## Test plan

- Reset, cfg_load dly=3, feed 1,2,3,4,5 on consecutive cycles -> out_valid pulses only with inputs 4,5, emitting 1,2; primed rises after the third sample.
- dly=1 with gapped in_valid (every third cycle), inputs 10,20,30 -> out 10 then 20, each out_valid one cycle after the respective in_valid, and out holds between strobes.
- dly_cfg=64 and 200 continuous ramp samples 0..199 -> out_valid first with input 64 emitting 0, last emitting 135; checks wrap and read-before-write.
- Mid-stream cfg_load dly=2 coincident with in_valid (sample 50), then 51, 52 -> no out_valid for 50 or 51, out=50 with 52; clamps: dly_cfg=0 behaves as 1, dly_cfg=100 behaves as 64.
- Assert rst low mid-stream while dly=4 -> out=0, out_valid=0, primed=0 immediately (asynchronous). After release, dly=1 is active; re-load 4 and verify four fresh samples before the first out_valid.

Source files
------------

// File: rtl/delay_12_ring_pkg.sv
// Shared peripheral constants for the 12-bit sample delay family.
package delay_12_ring_pkg;

  localparam int SAMPLE_W        = 12;
  localparam int DELAY_DEPTH_DEF = 64;

endpackage

// File: rtl/delay_12_ring_if.sv
// Sample stream, delay configuration and delayed-stream status.
interface delay_12_ring_if #(
  parameter int WIDTH = 12,
  parameter int AW    = 6
);
  logic             in_valid;
  logic [WIDTH-1:0] in;
  logic             cfg_load;
  logic [AW:0]      dly_cfg;
  logic [WIDTH-1:0] out;
  logic             out_valid;
  logic             primed;

  modport master (
    output in_valid, in, cfg_load, dly_cfg,
    input  out, out_valid, primed
  );

  modport slave (
    input  in_valid, in, cfg_load, dly_cfg,
    output out, out_valid, primed
  );
endinterface

// File: rtl/delay_12_ring_mem.sv
// Simple dual-port sample store: synchronous write, asynchronous read.
// Read-before-write comes from the caller registering rdata on the same
// edge that performs the write. Kept on its own so a macro can replace it.
module delay_12_ring_mem #(
  parameter int WIDTH = 12,
  parameter int DEPTH = 64,
  parameter int AW    = 6
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  // Write port; contents are deliberately not reset.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/delay_12_ring.sv
// Programmable sample-count delay over a circular buffer. The read tap sits
// dly samples behind the write pointer; fill tracks how many samples have
// been accepted since the last flush so stale history is never emitted.
module delay_12_ring
  import delay_12_ring_pkg::*;
#(
  parameter int WIDTH = SAMPLE_W,
  parameter int DEPTH = DELAY_DEPTH_DEF,
  parameter int AW    = $clog2(DEPTH)
) (
  input logic            clk,
  input logic            rst,
  delay_12_ring_if.slave bus
);

  localparam logic [AW:0] DEPTH_V = (AW+1)'(DEPTH);

  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_addr;
  logic [AW:0]      fill, fill_nxt;
  logic [AW:0]      dly, dly_nxt;
  logic [AW:0]      cfg_clamped;
  logic [WIDTH-1:0] rd_data;
  logic [WIDTH-1:0] out_q;
  logic             out_valid_q;
  logic             primed_q;
  logic             emit;

  // Clamp requested delay into 1..DEPTH.
  always_comb begin
    cfg_clamped = bus.dly_cfg;
    if (bus.dly_cfg == '0)          cfg_clamped = (AW+1)'(1);
    else if (bus.dly_cfg > DEPTH_V) cfg_clamped = DEPTH_V;
  end

  // Tap address uses the pre-write pointer; dly=DEPTH aliases wr_ptr and
  // reads the oldest entry just before it is overwritten.
  assign rd_addr = wr_ptr - dly[AW-1:0];

  // A sample coincident with cfg_load only seeds the new history.
  assign emit = bus.in_valid && !bus.cfg_load && (fill >= dly);

  // Next fill/delay: flush on load, otherwise count up and saturate at DEPTH.
  always_comb begin
    dly_nxt  = dly;
    fill_nxt = fill;
    if (bus.cfg_load) begin
      dly_nxt  = cfg_clamped;
      fill_nxt = bus.in_valid ? (AW+1)'(1) : '0;
    end else if (bus.in_valid && fill != DEPTH_V) begin
      fill_nxt = fill + (AW+1)'(1);
    end
  end

  delay_12_ring_mem #(.WIDTH(WIDTH), .DEPTH(DEPTH), .AW(AW)) u_mem (
    .clk   (clk),
    .we    (bus.in_valid),
    .waddr (wr_ptr),
    .wdata (bus.in),
    .raddr (rd_addr),
    .rdata (rd_data)
  );

  // Pointer, fill, delay and output registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr      <= '0;
      fill        <= '0;
      dly         <= (AW+1)'(1);
      out_q       <= '0;
      out_valid_q <= 1'b0;
      primed_q    <= 1'b0;
    end else begin
      if (bus.in_valid) wr_ptr <= wr_ptr + AW'(1);
      fill        <= fill_nxt;
      dly         <= dly_nxt;
      out_valid_q <= emit;
      if (emit) out_q <= rd_data;
      primed_q    <= bus.cfg_load ? 1'b0 : (fill_nxt >= dly_nxt);
    end
  end

  assign bus.out       = out_q;
  assign bus.out_valid = out_valid_q;
  assign bus.primed    = primed_q;

endmodule

// File: tb/tb_delay_12_ring.sv
// Randomized + directed bench for delay_12_ring. The reference keeps the
// samples accepted since the last flush in a queue; a sample emerges once
// at least dly earlier samples exist, and it is the one dly positions back.
module tb_delay_12_ring;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  delay_12_ring_if #(.WIDTH(12), .AW(6)) bus ();

  delay_12_ring dut (.clk(clk), .rst(rst), .bus(bus));

  int checks = 0;
  int errors = 0;

  logic [11:0] hist [$];
  logic [11:0] expq [$];
  int          mdly = 1;
  logic        exp_vld = 1'b0;
  logic        exp_primed = 1'b0;
  logic [11:0] last_out = '0;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d", nm, act, exp);
    end
  endtask

  function automatic int clampf(input int c);
    if (c == 0) return 1;
    if (c > 64) return 64;
    return c;
  endfunction

  // Reference model: updates expectations for the state after each edge.
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      hist.delete();
      expq.delete();
      mdly       = 1;
      exp_vld    = 1'b0;
      exp_primed = 1'b0;
    end else begin
      exp_vld = 1'b0;
      if (bus.cfg_load) begin
        mdly = clampf(int'(bus.dly_cfg));
        hist.delete();
        if (bus.in_valid) hist.push_back(bus.in);
        exp_primed = 1'b0;
      end else begin
        if (bus.in_valid) begin
          if (hist.size() >= mdly) begin
            expq.push_back(hist[hist.size() - mdly]);
            exp_vld = 1'b1;
          end
          hist.push_back(bus.in);
          if (hist.size() > 64) void'(hist.pop_front());
        end
        exp_primed = (hist.size() >= mdly);
      end
    end
  end

  // Monitor: pops the scoreboard on each out_valid, checks hold otherwise.
  always @(negedge clk) begin
    if (!rst) begin
      last_out = '0;
    end else begin
      chk("out_valid", int'(bus.out_valid), int'(exp_vld));
      chk("primed", int'(bus.primed), int'(exp_primed));
      if (bus.out_valid) begin
        if (expq.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_out actual=%0d expected=none", bus.out);
        end else begin
          logic [11:0] e;
          e = expq.pop_front();
          chk("out", int'(bus.out), int'(e));
          last_out = e;
        end
      end else begin
        chk("out_hold", int'(bus.out), int'(last_out));
      end
    end
  end

  task automatic drive(input logic v, input logic [11:0] d,
                       input logic ld, input logic [6:0] c);
    bus.in_valid = v;
    bus.in       = d;
    bus.cfg_load = ld;
    bus.dly_cfg  = c;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    bus.cfg_load = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 12'd0, 1'b0, 7'd0);
  endtask

  initial begin
    bus.in_valid = 1'b0;
    bus.in       = '0;
    bus.cfg_load = 1'b0;
    bus.dly_cfg  = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out", int'(bus.out), 0);
    chk("rst_out_valid", int'(bus.out_valid), 0);
    chk("rst_primed", int'(bus.primed), 0);
    rst = 1'b1;
    idle(2);

    // dly=3, samples 1..5: emits 1 with 4 and 2 with 5.
    drive(1'b0, 12'd0, 1'b1, 7'd3);
    for (int i = 1; i <= 5; i++) begin
      drive(1'b1, 12'(i), 1'b0, 7'd0);
      if (i == 3) chk("t1_primed_after3", int'(bus.primed), 1);
      if (i == 4) chk("t1_out_at4", int'(bus.out), 1);
      if (i == 5) chk("t1_out_at5", int'(bus.out), 2);
    end
    idle(2);

    // dly=1 with gapped strobes.
    drive(1'b0, 12'd0, 1'b1, 7'd1);
    drive(1'b1, 12'd10, 1'b0, 7'd0); idle(2);
    drive(1'b1, 12'd20, 1'b0, 7'd0); idle(2);
    drive(1'b1, 12'd30, 1'b0, 7'd0); idle(2);

    // dly=64 over a 200-sample ramp: wrap and read-before-write.
    drive(1'b0, 12'd0, 1'b1, 7'd64);
    for (int i = 0; i < 200; i++) begin
      drive(1'b1, 12'(i), 1'b0, 7'd0);
      if (i == 64) chk("t3_first_out", int'(bus.out), 0);
    end
    chk("t3_last_out", int'(bus.out), 135);

    // Load coincident with a sample: 50 seeds history, 52 emits 50.
    drive(1'b1, 12'd50, 1'b1, 7'd2);
    chk("t4_no_valid_50", int'(bus.out_valid), 0);
    drive(1'b1, 12'd51, 1'b0, 7'd0);
    chk("t4_no_valid_51", int'(bus.out_valid), 0);
    drive(1'b1, 12'd52, 1'b0, 7'd0);
    chk("t4_out_52", int'(bus.out), 50);

    // Clamps: 0 behaves as 1, 100 as 64.
    drive(1'b0, 12'd0, 1'b1, 7'd0);
    for (int i = 0; i < 4; i++) drive(1'b1, 12'(300 + i), 1'b0, 7'd0);
    drive(1'b0, 12'd0, 1'b1, 7'd100);
    for (int i = 0; i < 70; i++) drive(1'b1, 12'(1000 + i), 1'b0, 7'd0);
    chk("clamp64_out", int'(bus.out), 1005);

    // Async reset mid-stream with dly=4.
    drive(1'b0, 12'd0, 1'b1, 7'd4);
    for (int i = 0; i < 6; i++) drive(1'b1, 12'(700 + i), 1'b0, 7'd0);
    bus.in_valid = 1'b1;
    bus.in       = 12'd777;
    #2 rst = 1'b0;
    #1;
    chk("arst_out", int'(bus.out), 0);
    chk("arst_out_valid", int'(bus.out_valid), 0);
    chk("arst_primed", int'(bus.primed), 0);
    bus.in_valid = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b1;
    drive(1'b1, 12'd11, 1'b0, 7'd0);
    drive(1'b1, 12'd12, 1'b0, 7'd0);
    chk("post_rst_dly1", int'(bus.out), 11);
    drive(1'b0, 12'd0, 1'b1, 7'd4);
    for (int i = 0; i < 6; i++) drive(1'b1, 12'(800 + i), 1'b0, 7'd0);

    // Randomized traffic with occasional reconfiguration.
    for (int i = 0; i < 600; i++) begin
      drive(($urandom_range(0, 9) < 7) ? 1'b1 : 1'b0,
            12'($urandom_range(0, 4095)),
            ($urandom_range(0, 39) == 0) ? 1'b1 : 1'b0,
            7'($urandom_range(0, 127)));
    end
    idle(3);
    chk("scoreboard_drained", expq.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
